msg_framer: RTL and testbench
=============================

Name: msg_framer

Overview:
- Transmit-side framer that sits directly upstream of the sequence parser.
- Takes a message descriptor (stream id, payload byte count) and a 32-bit payload word stream.
- Emits the framed 32-bit little-endian word stream the parser consumes: word0 = {length, stream}, word1 = seq, then payload words, with val/ready/last.
- Keeps a per-stream sequence counter, so each stream's frames are numbered 0, 1, 2, … without gaps.

Parameters:
- NUM_STREAMS, 16, number of stream ids with their own sequence counter.
- STREAM_W, 4, width of msg_stream (log2 NUM_STREAMS).
- MAX_PAYLOAD, 40, largest accepted payload byte count. The on-wire length is payload + 8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- msg_stream  in  STREAM_W  stream id of the next message
- msg_len  in  16  payload byte count (excludes the 8 header bytes)
- msg_val  in  1  descriptor valid
- msg_ready  out  1  descriptor accepted when msg_val && msg_ready
- pay_data  in  32  payload word; byte 0 is in [31:24]
- pay_val  in  1  payload word valid
- pay_ready  out  1  payload word consumed when pay_val && pay_ready
- dataOut  out  32  framed word to the parser
- dataOut_val  out  1  framed word valid
- dataOut_ready  in  1  parser ready
- dataOut_last  out  1  marks the final word of a frame
- err_len  out  1  one-cycle pulse: descriptor rejected because msg_len > MAX_PAYLOAD

Behaviour:
- Reset (synchronous, active-high, dominant over everything):
  - State goes to IDLE and all sequence counters go to 0.
  - msg_ready, pay_ready, dataOut_val, dataOut_last and err_len are 0; dataOut is 0.
  - Reset mid-frame abandons the frame; no resumption.
- IDLE:
  - msg_ready = 1; all other handshake outputs are 0.
  - On accept with msg_len <= MAX_PAYLOAD: latch stream, L = msg_len + 8, seq = cnt[stream]. Then post-increment cnt[stream] (32-bit wrap, 0xFFFFFFFF -> 0) and go to HDR0.
  - On accept with msg_len > MAX_PAYLOAD: pulse err_len the next cycle, stay in IDLE, consume no payload, leave the counter unchanged.
- HDR0:
  - dataOut = {L[7:0], L[15:8], stream16[7:0], stream16[15:8]}, where stream16 is msg_stream zero-extended to 16 bits.
  - dataOut_val = 1; go to HDR1 on dataOut_ready.
- HDR1:
  - dataOut = {seq[7:0], seq[15:8], seq[23:16], seq[31:24]}, dataOut_val = 1.
  - If msg_len == 0: dataOut_last = 1 and return to IDLE on ready.
  - Otherwise load the word counter with ceil(msg_len/4) and go to PAY on ready.
- PAY (pass-through, zero added latency):
  - dataOut = pay_data, dataOut_val = pay_val, pay_ready = dataOut_ready.
  - dataOut_last = 1 when the word counter == 1.
  - Decrement the counter on each transfer; the last transfer returns to IDLE.
  - Surplus payload words stay unconsumed; they belong to the next message.
- Latency: first header word is valid the cycle after descriptor accept. A frame with P payload words needs at least P+2 transfer cycles plus 1 idle accept cycle.
- Handshake rules:
  - dataOut and dataOut_last stay stable while dataOut_val && !dataOut_ready.
  - Header words never depend on pay_val.
  - msg_ready = 0 outside IDLE, so there is no descriptor overlap.

Optional Feature:
- Macro: MSG_FRAMER_ZERO_PAD_EN.
- Defined: on the last payload word, bytes beyond msg_len are forced to 0. Byte k of the word is kept iff k < (msg_len mod 4), or all bytes are kept when msg_len mod 4 == 0.
- Undefined: the last word is passed through unmodified.

Decomposition:
- Package msg_pkg holds:
  - Header byte-swap functions le16/le32.
  - State enum {IDLE, HDR0, HDR1, PAY}.
  - Constants HDR_BYTES = 8 and WORD_BYTES = 4.
- One sub-module, seq_table: NUM_STREAMS x 32-bit counter array with read-and-increment port and synchronous clear.

Test Plan:
- Descriptor (12, len 12) with 3 payload words, ready held 1 -> words 0x14000C00, 0x00000000, then the 3 payload words; last on word 5; msg_ready back to 1 the next cycle.
- Second descriptor on stream 12 and one on stream 13, each len 12 -> stream 12 word1 = 0x01000000; stream 13 word1 = 0x00000000.
- Descriptor len 0 on stream 3 -> two words 0x08000300, seq word; last on word 2; pay_ready never asserted.
- Descriptor len 41 -> err_len pulses once, no dataOut_val. Following len 4 on the same stream -> seq still 0.
- dataOut_ready toggled 1/0 every cycle during a len-13 frame -> each word held stable until accepted, 6 transfers, no loss or duplication. With MSG_FRAMER_ZERO_PAD_EN, last word 0xAABBCCDD -> 0xAA000000.
- Reset asserted in PAY of a frame on stream 5 -> next cycle all outputs 0. A new stream-5 frame then carries seq 0.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared types and helpers for the msg_framer transmit framer.
// MSG_FRAMER_ZERO_PAD_EN selects the pad_mask path in the top.
package msg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR0,
        HDR1,
        PAY
    } state_t;

    localparam logic [15:0] HDR_BYTES  = 16'd8;
    localparam logic [15:0] WORD_BYTES = 16'd4;

    function automatic logic [15:0] le16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] le32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // Byte 0 sits in [31:24]; keep the first rem bytes, all when rem == 0.
    function automatic logic [31:0] pad_mask(input logic [1:0] rem);
        logic [31:0] m;
        unique case (rem)
            2'd1:    m = 32'hFF00_0000;
            2'd2:    m = 32'hFFFF_0000;
            2'd3:    m = 32'hFFFF_FF00;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/seq_table.sv
// Per-stream 32-bit sequence counters for msg_framer.
// Combinational read, post-increment on inc_i, synchronous clear.
module seq_table #(
    parameter int NUM_STREAMS = 16,
    parameter int STREAM_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [STREAM_W-1:0] idx_i,
    input  logic                inc_i,
    output logic [31:0]         cnt_o
);

    logic [31:0] cnt_q [NUM_STREAMS];
    logic [31:0] cnt_d [NUM_STREAMS];

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d[idx_i] = cnt_q[idx_i] + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q[idx_i];

endmodule

// File: rtl/msg_framer.sv
// Transmit framer: {len,stream} header, seq word, then payload pass-through.
// Define MSG_FRAMER_ZERO_PAD_EN to zero bytes past msg_len in the last word.
module msg_framer #(
    parameter int NUM_STREAMS = 16,
    parameter int STREAM_W    = 4,
    parameter int MAX_PAYLOAD = 40
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [STREAM_W-1:0] msg_stream,
    input  logic [15:0]         msg_len,
    input  logic                msg_val,
    output logic                msg_ready,
    input  logic [31:0]         pay_data,
    input  logic                pay_val,
    output logic                pay_ready,
    output logic [31:0]         dataOut,
    output logic                dataOut_val,
    input  logic                dataOut_ready,
    output logic                dataOut_last,
    output logic                err_len
);

    import msg_pkg::*;

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    state_t              state_q, state_d;
    logic [STREAM_W-1:0] stream_q, stream_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         plen_q, plen_d;
    logic [15:0]         wcnt_q, wcnt_d;
    logic [31:0]         seq_q, seq_d;
    logic                err_q, err_d;
    logic                inc;
    logic [31:0]         cnt_rd;
    logic [31:0]         pay_word;

    seq_table #(
        .NUM_STREAMS(NUM_STREAMS),
        .STREAM_W   (STREAM_W)
    ) u_seq (
        .clk  (clk),
        .reset(reset),
        .idx_i(msg_stream),
        .inc_i(inc),
        .cnt_o(cnt_rd)
    );

`ifdef MSG_FRAMER_ZERO_PAD_EN
    assign pay_word = (wcnt_q == 16'd1) ? (pay_data & pad_mask(plen_q[1:0]))
                                        : pay_data;
`else
    assign pay_word = pay_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            stream_q <= '0;
            len_q    <= '0;
            plen_q   <= '0;
            wcnt_q   <= '0;
            seq_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stream_q <= stream_d;
            len_q    <= len_d;
            plen_q   <= plen_d;
            wcnt_q   <= wcnt_d;
            seq_q    <= seq_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stream_d     = stream_q;
        len_d        = len_q;
        plen_d       = plen_q;
        wcnt_d       = wcnt_q;
        seq_d        = seq_q;
        err_d        = 1'b0;
        inc          = 1'b0;
        msg_ready    = 1'b0;
        pay_ready    = 1'b0;
        dataOut      = '0;
        dataOut_val  = 1'b0;
        dataOut_last = 1'b0;
        err_len      = err_q;

        unique case (state_q)
            IDLE: begin
                msg_ready = 1'b1;
                if (msg_val && !reset) begin
                    if (msg_len > MAX_LEN) begin
                        err_d = 1'b1;
                    end else begin
                        stream_d = msg_stream;
                        plen_d   = msg_len;
                        len_d    = msg_len + HDR_BYTES;
                        seq_d    = cnt_rd;
                        inc      = 1'b1;
                        state_d  = HDR0;
                    end
                end
            end
            HDR0: begin
                dataOut     = {le16(len_q), le16(16'(stream_q))};
                dataOut_val = 1'b1;
                if (dataOut_ready) begin
                    state_d = HDR1;
                end
            end
            HDR1: begin
                dataOut      = le32(seq_q);
                dataOut_val  = 1'b1;
                dataOut_last = (plen_q == 16'd0);
                if (dataOut_ready) begin
                    if (plen_q == 16'd0) begin
                        state_d = IDLE;
                    end else begin
                        wcnt_d  = (plen_q + WORD_BYTES - 16'd1) / WORD_BYTES;
                        state_d = PAY;
                    end
                end
            end
            PAY: begin
                dataOut      = pay_word;
                dataOut_val  = pay_val;
                pay_ready    = dataOut_ready;
                dataOut_last = (wcnt_q == 16'd1);
                if (pay_val && dataOut_ready) begin
                    wcnt_d = wcnt_q - 16'd1;
                    if (wcnt_q == 16'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset dominates: every handshake output is quiet during it.
        if (reset) begin
            msg_ready    = 1'b0;
            pay_ready    = 1'b0;
            dataOut      = '0;
            dataOut_val  = 1'b0;
            dataOut_last = 1'b0;
            err_len      = 1'b0;
        end
    end

endmodule

// File: tb/tb_msg_framer.sv
// Scoreboard bench for msg_framer with a queue-based frame model.
// Build with MSG_FRAMER_ZERO_PAD_EN to check last-word padding.
module tb_msg_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  msg_stream;
    logic [15:0] msg_len;
    logic        msg_val;
    logic        msg_ready;
    logic [31:0] pay_data;
    logic        pay_val;
    logic        pay_ready;
    logic [31:0] dataOut;
    logic        dataOut_val;
    logic        dataOut_ready;
    logic        dataOut_last;
    logic        err_len;

    typedef struct packed {
        logic        last;
        logic [31:0] w;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] pay_q[$];
    int unsigned cnt_m[16];
    int          tests = 0;
    int          fails = 0;
    int          rdy_mode = 0;

    logic        pay_fire, last_fire, prev_hold, hdr_due, err_due;
    logic [31:0] prev_data;
    logic        prev_last;

    msg_framer dut (
        .clk          (clk),
        .reset        (reset),
        .msg_stream   (msg_stream),
        .msg_len      (msg_len),
        .msg_val      (msg_val),
        .msg_ready    (msg_ready),
        .pay_data     (pay_data),
        .pay_val      (pay_val),
        .pay_ready    (pay_ready),
        .dataOut      (dataOut),
        .dataOut_val  (dataOut_val),
        .dataOut_ready(dataOut_ready),
        .dataOut_last (dataOut_last),
        .err_len      (err_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Frame model: header bytes little-endian, payload words in order.
    function automatic void model_accept(input int s, input int len,
                                         input bit fl, input logic [31:0] lw);
        beat_t       b;
        int          n;
        int unsigned L;
        int unsigned sq;
        logic [31:0] w;
        if (len > 40) return;
        L = 32'(len + 8);
        b.w = 32'(((L & 255) << 24) | ((L >> 8) << 16) | (s << 8));
        b.last = 1'b0;
        exp_q.push_back(b);
        sq = cnt_m[s];
        cnt_m[s] = sq + 1;
        w = 0;
        for (int i = 0; i < 4; i++) w |= ((sq >> (8 * i)) & 255) << (24 - 8 * i);
        b.w = w;
        b.last = (len == 0);
        exp_q.push_back(b);
        n = (len + 3) / 4;
        for (int i = 0; i < n; i++) begin
            w = $urandom();
            if (fl && i == n - 1) w = lw;
            pay_q.push_back(w);
`ifdef MSG_FRAMER_ZERO_PAD_EN
            if (i == n - 1 && (len % 4) != 0)
                w = w & ~(32'hFFFF_FFFF >> (8 * (len % 4)));
`endif
            b.w = w;
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
    endfunction

    task automatic send(input int s, input int len, input bit fl,
                        input logic [31:0] lw);
        bit ok;
        @(posedge clk);
        #1;
        msg_val    = 1'b1;
        msg_stream = s[3:0];
        msg_len    = len[15:0];
        ok = 1'b0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk);
            if (msg_ready) ok = 1'b1;
        end
        if (!ok) begin
            fail_now("desc_accept_timeout");
            msg_val = 1'b0;
            return;
        end
        model_accept(s, len, fl, lw);
        @(posedge clk);
        #1;
        msg_val = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || pay_q.size() != 0) && c < 3000) begin
            @(posedge clk);
            c++;
        end
        if (c >= 3000) fail_now("drain_timeout");
        repeat (2) @(posedge clk);
    endtask

    // Monitor: all sampling on the falling edge.
    initial begin
        beat_t b;
        pay_fire = 0; last_fire = 0; prev_hold = 0; hdr_due = 0; err_due = 0;
        prev_data = 0; prev_last = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("reset_outs",
                      64'({msg_ready, pay_ready, dataOut_val, dataOut_last,
                           err_len, dataOut}), 64'd0);
                pay_fire = 0; last_fire = 0; prev_hold = 0;
                hdr_due = 0; err_due = 0;
            end else begin
                if (prev_hold) begin
                    check("hold_val", 64'(dataOut_val), 64'd1);
                    check("hold_data", 64'({dataOut_last, dataOut}),
                          64'({prev_last, prev_data}));
                end
                if (hdr_due) check("hdr_latency", 64'(dataOut_val), 64'd1);
                if (last_fire) check("ready_after_last", 64'(msg_ready), 64'd1);
                if (err_due || err_len) check("err_len", 64'(err_len), 64'(err_due));
                last_fire = 0;
                if (dataOut_val && dataOut_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_word");
                    end else begin
                        b = exp_q.pop_front();
                        check("word", 64'({dataOut_last, dataOut}),
                              64'({b.last, b.w}));
                    end
                    last_fire = dataOut_last;
                end
                pay_fire = pay_val && pay_ready;
                if (pay_fire && pay_q.size() == 0) fail_now("unexpected_pay_consume");
                prev_hold = dataOut_val && !dataOut_ready;
                prev_data = dataOut;
                prev_last = dataOut_last;
                hdr_due = msg_val && msg_ready && (msg_len <= 16'd40);
                err_due = msg_val && msg_ready && (msg_len > 16'd40);
            end
        end
    end

    // Payload source: holds a word until it is consumed.
    initial begin
        pay_val  = 1'b0;
        pay_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pay_fire && pay_q.size() > 0) begin
                pay_q.delete(0);
                pay_val = 1'b0;
            end
            if (!pay_val && pay_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                pay_val  = 1'b1;
                pay_data = pay_q[0];
            end
        end
    end

    initial begin
        dataOut_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       dataOut_ready = 1'b1;
                1:       dataOut_ready = ~dataOut_ready;
                default: dataOut_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset      = 1'b1;
        msg_val    = 1'b0;
        msg_stream = '0;
        msg_len    = '0;
        foreach (cnt_m[i]) cnt_m[i] = 0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset",
              64'({msg_ready, pay_ready, dataOut_val, dataOut_last, err_len}),
              64'h10);

        send(12, 12, 0, 0);
        drain();
        send(12, 12, 0, 0);
        send(13, 12, 0, 0);
        drain();
        send(3, 0, 0, 0);
        drain();
        send(7, 41, 0, 0);
        send(7, 4, 0, 0);
        drain();

        rdy_mode = 1;
        send(9, 13, 1, 32'hAABB_CCDD);
        drain();

        rdy_mode = 2;
        repeat (150) begin
            send(int'($urandom_range(0, 15)), int'($urandom_range(0, 44)), 0, 0);
        end
        drain();

        rdy_mode = 0;
        send(5, 40, 0, 0);
        c = 0;
        while (exp_q.size() > 8 && c < 500) begin
            @(posedge clk);
            c++;
        end
        if (c >= 500) fail_now("reach_pay_timeout");
        #1;
        reset = 1'b1;
        @(posedge clk);
        #2;
        exp_q.delete();
        pay_q.delete();
        pay_val = 1'b0;
        foreach (cnt_m[i]) cnt_m[i] = 0;
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_midframe_reset",
              64'({msg_ready, pay_ready, dataOut_val, dataOut_last, err_len}),
              64'h10);
        send(5, 8, 0, 0);
        send(5, 0, 0, 0);
        drain();

        if (exp_q.size() != 0 || pay_q.size() != 0) fail_now("queues_not_empty");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
